// File: rtl/am_transmitter.sv
// rtl/am_transmitter.sv - AM transmit path: sample interpolation, square-wave carrier, sigma-delta RF bit
module am_transmitter #(
  parameter int WIDTH       = 16,
  parameter int PERIOD_LOG2 = 13,
  parameter int PHASE_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   clock_sreset,
  input  logic [PHASE_WIDTH-1:0] phase_increment,
  input  logic [7:0]             mod_depth,
  input  logic                   data_valid,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   data_ready,
  output logic                   underrun,
  output logic [WIDTH-1:0]       envelope_out,
  output logic                   rf_out
);

  localparam int ACC_W  = WIDTH + PERIOD_LOG2 + 1;
  localparam int STEP_W = WIDTH + 1;
  localparam int PROD_W = WIDTH + 9;
  localparam int X_W    = WIDTH + 2;
  localparam int E_W    = WIDTH + 3;

  localparam logic [PROD_W-1:0] C_MID    = PROD_W'(2 ** (WIDTH - 1));
  localparam logic [E_W-1:0]    C_FB_POS = E_W'(2 ** WIDTH);
  localparam logic [E_W-1:0]    C_FB_NEG = E_W'(0) - C_FB_POS;

  // slot / handshake state
  logic [PERIOD_LOG2-1:0] r_slot_cnt;
  logic                   r_hold_valid;
  logic [WIDTH-1:0]       r_hold;
  logic [WIDTH-1:0]       r_target;
  logic [STEP_W-1:0]      r_step;
  logic                   r_underrun;

  // interpolation / modulation state
  logic [ACC_W-1:0]       r_acc;
  logic [WIDTH-1:0]       r_env;
  logic [PHASE_WIDTH-1:0] r_phase;
  logic [E_W-1:0]         r_err;
  logic                   r_rf;

  logic                   w_boundary;
  logic                   w_accept;
  logic [STEP_W-1:0]      w_step_new;
  logic [ACC_W-1:0]       w_step_ext;
  logic [ACC_W-1:0]       w_acc_shift;
  logic [ACC_W-WIDTH:0]   w_acc_hi;
  logic [WIDTH-1:0]       w_interp;
  logic [PROD_W-1:0]      w_interp_ext;
  logic [PROD_W-1:0]      w_depth_ext;
  logic [PROD_W-1:0]      w_prod;
  logic [PROD_W-1:0]      w_scaled;
  logic [PROD_W-1:0]      w_sum;
  logic [WIDTH-1:0]       w_env_next;
  logic [X_W-1:0]         w_env_ext;
  logic [X_W-1:0]         w_x;
  logic [E_W-1:0]         w_fb;
  logic [E_W-1:0]         w_err_next;

  assign w_boundary = &r_slot_cnt;
  assign w_accept   = data_valid & ~r_hold_valid;

  // Step is taken from the exact previous target, so the ramp lands on the new sample with no residue
  assign w_step_new = {r_hold[WIDTH-1], r_hold} - {r_target[WIDTH-1], r_target};
  assign w_step_ext = {{(ACC_W-STEP_W){r_step[STEP_W-1]}}, r_step};

  assign w_acc_shift = $signed(r_acc) >>> PERIOD_LOG2;
  assign w_acc_hi    = w_acc_shift[ACC_W-1:WIDTH-1];

  // Interpolated sample; the saturation branch is unreachable in normal operation but keeps the slice honest
  always_comb begin
    w_interp = w_acc_shift[WIDTH-1:0];
    if (!((&w_acc_hi) | ~(|w_acc_hi))) begin
      w_interp = w_acc_hi[ACC_W-WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign w_interp_ext = {{(PROD_W-WIDTH){w_interp[WIDTH-1]}}, w_interp};
  assign w_depth_ext  = {{(PROD_W-8){1'b0}}, mod_depth};
  assign w_prod       = $signed(w_interp_ext) * $signed(w_depth_ext);
  assign w_scaled     = $signed(w_prod) >>> 8;
  assign w_sum        = w_scaled + C_MID;

  // Clamp the offset envelope into the unsigned output range
  always_comb begin
    w_env_next = w_sum[WIDTH-1:0];
    if (w_sum[PROD_W-1]) begin
      w_env_next = '0;
    end else if (|w_sum[PROD_W-2:WIDTH]) begin
      w_env_next = '1;
    end
  end

  // Square-wave carrier: phase MSB selects the sign applied to the envelope
  assign w_env_ext  = {2'b00, r_env};
  assign w_x        = r_phase[PHASE_WIDTH-1] ? (X_W'(0) - w_env_ext) : w_env_ext;
  assign w_fb       = r_rf ? C_FB_POS : C_FB_NEG;
  assign w_err_next = r_err + {w_x[X_W-1], w_x} - w_fb;

  // Slot counter, one-deep holding register and per-slot target/step update
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_slot_cnt   <= '0;
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
      r_target     <= '0;
      r_step       <= '0;
      r_underrun   <= 1'b0;
    end else begin
      r_slot_cnt <= r_slot_cnt + PERIOD_LOG2'(1);
      r_underrun <= 1'b0;
      if (w_boundary) begin
        if (r_hold_valid) begin
          r_target     <= r_hold;
          r_step       <= w_step_new;
          r_hold_valid <= 1'b0;
        end else begin
          r_step     <= '0;
          r_underrun <= 1'b1;
        end
      end
      // accept only happens with the holding register empty, so it never races the consume above
      if (w_accept) begin
        r_hold       <= data_in;
        r_hold_valid <= 1'b1;
      end
    end
  end

  // Linear interpolator: accumulate the per-slot step every clock
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_acc <= '0;
    end else begin
      r_acc <= r_acc + w_step_ext;
    end
  end

  // Registered modulated envelope
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_env <= '0;
    end else begin
      r_env <= w_env_next;
    end
  end

  // Carrier NCO and first-order sigma-delta modulator
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_phase <= '0;
      r_err   <= '0;
      r_rf    <= 1'b0;
    end else begin
      r_phase <= r_phase + phase_increment;
      r_err   <= w_err_next;
      r_rf    <= ~w_err_next[E_W-1];
    end
  end

  assign data_ready   = ~r_hold_valid;
  assign underrun     = r_underrun;
  assign envelope_out = r_env;
  assign rf_out       = r_rf;

endmodule

// File: tb/tb_am_transmitter.sv
// tb/tb_am_transmitter.sv - scoreboard bench for am_transmitter
module tb_am_transmitter;

  localparam int K_ENV  = 0;
  localparam int K_RDY  = 1;
  localparam int K_RF   = 2;
  localparam int K_MARK = 3;
  localparam int K_DENS = 4;

  typedef struct {
    int    at;
    int    kind;
    int    exp;
    int    tol;
    string name;
  } chk_t;

  typedef struct {
    int edge_n;
    int val;
  } acc_t;

  logic        clock;
  logic        clock_sreset;
  logic [31:0] phase_increment;
  logic [7:0]  mod_depth;
  logic        data_valid;
  logic [15:0] data_in;
  logic        data_ready;
  logic        underrun;
  logic [15:0] envelope_out;
  logic        rf_out;

  int n_edge = 0;
  int n_tests = 0;
  int n_fail = 0;

  chk_t chk_q[$];
  int   urun_q[$];
  acc_t acc_q[$];

  am_transmitter #(
    .WIDTH(16),
    .PERIOD_LOG2(13),
    .PHASE_WIDTH(32)
  ) dut (
    .clock(clock),
    .clock_sreset(clock_sreset),
    .phase_increment(phase_increment),
    .mod_depth(mod_depth),
    .data_valid(data_valid),
    .data_in(data_in),
    .data_ready(data_ready),
    .underrun(underrun),
    .envelope_out(envelope_out),
    .rf_out(rf_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // edges since the last reset edge
  always @(posedge clock) begin
    if (clock_sreset) n_edge <= 0;
    else              n_edge <= n_edge + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d (0x%0h), expected %0d (0x%0h)", name, n_edge, act, act, exp, exp);
    end
  endtask

  function automatic void push_chk(input int at, input int kind, input int exp, input int tol, input string name);
    chk_t c;
    c.at = at; c.kind = kind; c.exp = exp; c.tol = tol; c.name = name;
    chk_q.push_back(c);
  endfunction

  function automatic void push_acc(input int edge_n, input int val);
    acc_t a;
    a.edge_n = edge_n; a.val = val;
    acc_q.push_back(a);
  endfunction

  task automatic wait_n(input int target);
    while (n_edge < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // monitor: compares DUT outputs against the queued expectations
  initial begin
    chk_t c;
    acc_t a;
    int   rf_cum;
    int   rf_mark;
    int   ones;
    rf_cum  = 0;
    rf_mark = 0;
    forever begin
      @(negedge clock);
      if (!clock_sreset) rf_cum += int'(rf_out);

      if (!clock_sreset && data_valid && data_ready) begin
        if (acc_q.size() == 0) begin
          check("accept_stray", int'(data_in), -1);
        end else begin
          a = acc_q.pop_front();
          check("accept_edge", n_edge + 1, a.edge_n);
          check("accept_value", int'(data_in), a.val);
        end
      end

      if (urun_q.size() > 0 && !clock_sreset && urun_q[0] < n_edge) begin
        check("underrun_missing", urun_q[0], n_edge);
        void'(urun_q.pop_front());
      end
      if (underrun === 1'b1) begin
        if (urun_q.size() > 0 && urun_q[0] == n_edge) begin
          check("underrun_at", n_edge, urun_q.pop_front());
        end else begin
          check("underrun_stray", n_edge, -1);
        end
      end

      while (chk_q.size() > 0 && chk_q[0].at <= n_edge) begin
        c = chk_q.pop_front();
        if (c.at != n_edge) begin
          check({c.name, "_missed"}, n_edge, c.at);
        end else begin
          case (c.kind)
            K_ENV:  check(c.name, int'(envelope_out), c.exp);
            K_RDY:  check(c.name, int'(data_ready), c.exp);
            K_RF:   check(c.name, int'(rf_out), c.exp);
            K_MARK: rf_mark = rf_cum;
            default: begin
              ones = rf_cum - rf_mark;
              n_tests++;
              if (ones < c.exp - c.tol || ones > c.exp + c.tol) begin
                n_fail++;
                $display("FAIL %s: got %0d ones, expected %0d +/- %0d", c.name, ones, c.exp, c.tol);
              end
            end
          endcase
        end
      end
    end
  end

  // stimulus
  initial begin
    int n_acc;
    logic rdy_seen;
    clock_sreset    = 1'b1;
    phase_increment = 32'd0;
    mod_depth       = 8'd255;
    data_valid      = 1'b0;
    data_in         = 16'd0;

    push_chk(0, K_ENV, 0, 0, "rst_env");
    push_chk(0, K_RDY, 1, 0, "rst_ready");
    push_chk(0, K_RF,  0, 0, "rst_rf");
    repeat (4) @(posedge clock);
    #1 clock_sreset = 1'b0;

    push_chk(1,  K_ENV, 'h8000, 0, "idle_env_1");
    push_chk(2,  K_ENV, 'h8000, 0, "idle_env_2");
    push_chk(50, K_RDY, 1,      0, "idle_ready");
    push_chk(50, K_ENV, 'h8000, 0, "idle_env_50");
    urun_q.push_back(8192);

    // 0x4000 offered 100 clocks into the second slot, ramps from the 16384 boundary
    wait_n(8291);
    push_acc(8292, 'h4000);
    data_valid = 1'b1; data_in = 16'h4000;
    wait_n(8292);
    data_valid = 1'b0;
    push_chk(8292,  K_RDY, 0,      0, "hold_ready_low");
    push_chk(16384, K_RDY, 1,      0, "consume_ready_high");
    push_chk(16385, K_ENV, 'h8000, 0, "ramp_start");
    push_chk(16386, K_ENV, 'h8001, 0, "ramp_first_step");
    push_chk(20481, K_ENV, 'h9FE0, 0, "ramp_mid");

    wait_n(16483);
    push_acc(16484, 'h8000);
    data_valid = 1'b1; data_in = 16'h8000;
    wait_n(16484);
    data_valid = 1'b0;
    push_chk(24576, K_ENV, 'hBFBE, 0, "ramp_last_but_one");
    push_chk(24577, K_ENV, 'hBFC0, 0, "ramp_full");

    wait_n(24675);
    push_acc(24676, 'h7FFF);
    data_valid = 1'b1; data_in = 16'h7FFF;
    wait_n(24676);
    data_valid = 1'b0;
    push_chk(28673, K_ENV, 'h6020, 0, "neg_ramp_mid");
    push_chk(32769, K_ENV, 'h0080, 0, "clamp_low");
    push_chk(40960, K_ENV, 'hFF77, 0, "pos_ramp_last_but_one");
    push_chk(40961, K_ENV, 'hFF7F, 0, "clamp_high");
    urun_q.push_back(40960);

    // source holds data_valid high and advances only after each accept
    push_acc(40963, 100);
    push_acc(49153, 101);
    push_acc(57345, 102);
    push_chk(45000, K_RDY, 0,      0, "stream_ready_low_a");
    push_chk(53000, K_RDY, 0,      0, "stream_ready_low_b");
    push_chk(57345, K_ENV, 'h8063, 0, "stream_env_100");
    push_chk(59000, K_ENV, 'h8063, 0, "stream_env_hold");
    wait_n(40962);
    data_valid = 1'b1; data_in = 16'd100;
    n_acc = 0;
    while (n_acc < 3 && n_edge < 60000) begin
      rdy_seen = data_ready;
      @(posedge clock);
      #1;
      if (rdy_seen) begin
        n_acc++;
        data_in = data_in + 16'd1;
      end
    end
    data_valid = 1'b0;

    // reset mid-ramp with sample 102 still pending
    wait_n(60000);
    clock_sreset = 1'b1;
    @(posedge clock);
    #1;
    push_chk(0, K_RDY, 1, 0, "midreset_ready");
    push_chk(0, K_ENV, 0, 0, "midreset_env");
    push_chk(0, K_RF,  0, 0, "midreset_rf");
    @(posedge clock);
    #1 clock_sreset = 1'b0;
    push_chk(1,    K_ENV, 'h8000, 0, "post_reset_env");
    push_chk(1,    K_RDY, 1,      0, "post_reset_ready");
    push_chk(8193, K_ENV, 'h8000, 0, "post_reset_no_ramp");
    urun_q.push_back(8192);

    // carrier and sigma-delta density with a constant half-scale envelope
    wait_n(8200);
    mod_depth = 8'd0;
    push_chk(8300, K_MARK, 0,   0,  "dc_pos_mark");
    push_chk(9324, K_DENS, 768, 10, "dc_pos_density");
    wait_n(9330);
    phase_increment = 32'h8000_0000;
    wait_n(9331);
    phase_increment = 32'd0;
    push_chk(9400,  K_MARK, 0,   0,  "dc_neg_mark");
    push_chk(10424, K_DENS, 256, 10, "dc_neg_density");
    wait_n(10430);
    phase_increment = 32'h4000_0000;
    push_chk(10500, K_MARK, 0,   0,  "carrier_mark");
    push_chk(11524, K_DENS, 512, 10, "carrier_density");
    wait_n(11530);

    check("pending_checks", chk_q.size(), 0);
    check("pending_underruns", urun_q.size(), 0);
    check("pending_accepts", acc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, edge %0d", n_edge);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/am_transmitter.md
Name: am_transmitter

Overview:
- AM transmit path: accepts signed audio samples, linearly interpolates them to the system clock rate and applies amplitude modulation onto an NCO square-wave carrier.
- Drives a single-bit first-order sigma-delta RF output, which feeds an output pin and external reconstruction filter.
- Sits in the top level alongside am_receiver, on system_clock.
- Default sample period (8192 clocks) mirrors the receive decimation.

Parameters:
WIDTH, 16, audio sample width (signed two's complement)
PERIOD_LOG2, 13, log2 of clocks per audio sample slot (8192)
PHASE_WIDTH, 32, NCO phase accumulator width

Ports:
clock  in  1  system clock
clock_sreset  in  1  synchronous active-high reset
phase_increment  in  PHASE_WIDTH  carrier NCO increment, sampled every clock
mod_depth  in  8  modulation depth, unsigned, 0..255 (255 ≈ 100%)
data_valid  in  1  audio sample offered
data_in  in  WIDTH  signed audio sample
data_ready  out  1  holding register empty; sample accepted when data_valid & data_ready
underrun  out  1  one-clock pulse when a slot boundary finds no pending sample
envelope_out  out  WIDTH  current unsigned modulated amplitude (debug)
rf_out  out  1  sigma-delta RF bitstream

Behaviour:
- Reset (clock_sreset=1, synchronous): every register cleared. Outputs: data_ready=1, underrun=0, envelope_out=0, rf_out=0. Reset mid-slot discards any pending sample and the interpolation state.
- Input handshake: one-deep holding register.
  - data_ready = !hold_valid.
  - On data_valid & data_ready: latch data_in and set hold_valid.
  - data_valid with data_ready=0 is ignored; the source must hold the sample.
- Slot counter: PERIOD_LOG2 bits, free-running, wraps at 2^PERIOD_LOG2-1 → 0. The wrap clock is the slot boundary.
- At a slot boundary:
  - If hold_valid: target ← hold, step ← target_new − current (WIDTH+1 bits signed), hold_valid ← 0.
  - Else: target unchanged, step ← 0, underrun pulses for 1 clock.
  - A sample accepted on the boundary clock itself is pending only for the next boundary, not this one.
- Interpolator: accumulator of WIDTH+PERIOD_LOG2+1 bits, holding current<<PERIOD_LOG2. It adds step every clock, so it lands exactly on target<<PERIOD_LOG2 after 2^PERIOD_LOG2 clocks, with no multiplier in this path. Interpolated value interp = acc >> PERIOD_LOG2, signed WIDTH. A new sample therefore reaches full value 2^PERIOD_LOG2 clocks after the boundary that loaded it.
- Envelope (registered, 1 clock):
  - a = 2^(WIDTH-1) + ((interp × mod_depth) >>> 8), arithmetic shift.
  - Clamp to 0..2^WIDTH-1.
  - envelope_out = a.
- NCO:
  - phase += phase_increment each clock, wrapping modulo 2^PHASE_WIDTH.
  - Carrier sign = phase MSB: MSB=0 → +a, MSB=1 → −a.
  - x is signed WIDTH+2 bits.
- Sigma-delta (registered):
  - Error register e, signed WIDTH+3 bits, reset 0.
  - Feedback f = rf_out ? +2^WIDTH : −2^WIDTH.
  - e ← e + x − f.
  - rf_out ← (e_next ≥ 0).
  - |x| < 2^WIDTH guarantees e stays bounded; no saturation needed.
- Latency: envelope_out lags interp by 1 clock; rf_out lags envelope_out by 1 clock.
- Simultaneous accept and boundary with hold_valid=1: the boundary consumes the old hold, and data_ready was 0, so no accept occurs. Never lose or duplicate a sample.
- mod_depth=0: envelope constant 2^(WIDTH-1). The rf_out density then toggles with the carrier as a 50%-amplitude square wave.

Test Plan:
- Reset held 4 clocks, then released with no input → data_ready=1, rf_out=0 during reset; underrun pulses once per 8192 clocks; envelope_out=0x8000 from 2 clocks after release (interp=0, a=2^15).
- Offer 0x4000 with mod_depth=255 at clock 100 → accepted same clock (data_ready falls next clock). At the boundary, envelope_out ramps linearly from 0x8000, reaching 0x8000+(0x4000×255>>8)=0xBFC0 exactly 8192 clocks later. No underrun at that boundary.
- Offer −32768 then +32767, mod_depth=255 → envelope clamps to 0x0080 and 0xFF7F respectively; no wrap-around; clamp never exceeds 0..0xFFFF.
- Hold data_valid=1 continuously with an incrementing sample → exactly one accept per slot; data_ready low between accepts; no underrun; no skipped or duplicated values at the interp output.
- phase_increment=0x40000000, mod_depth=0 → carrier period 4 clocks. Over 1024 clocks the mean of rf_out over +carrier half-cycles ≈ 0.75 and over −half-cycles ≈ 0.25 (±1%).
- Assert clock_sreset mid-ramp with hold_valid=1 → next clock: data_ready=1, envelope/accumulator/phase cleared, pending sample discarded. Slot counter restarts, with the first boundary 8192 clocks after release.
